// File: rtl/zle_pkg.sv
// Shared constants and types for the ZLE stream blocks.
package zle_pkg;

   localparam int ZLE_W = 4;

   localparam logic TAG_A = 1'b0;
   localparam logic TAG_B = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_A = 2'd1,
      ST_GNT_B = 2'd2
   } zle_state_e;

endpackage

// File: rtl/zle_merge2_if.sv
// Token channel bundle between two ZLE encoders, the merger and the shared downstream channel.
interface zle_merge2_if
   import zle_pkg::*;
#(
   parameter int W = ZLE_W
);

   logic [W-1:0] a_d;
   logic         a_v;
   logic         a_b;
   logic [W-1:0] b_d;
   logic         b_v;
   logic         b_b;
   logic [W:0]   o_d;
   logic         o_v;
   logic         o_b;

   // Environment side: encoders and downstream consumer.
   modport master (
      output a_d, a_v, b_d, b_v, o_b,
      input  a_b, b_b, o_d, o_v
   );

   // Merger side.
   modport slave (
      input  a_d, a_v, b_d, b_v, o_b,
      output a_b, b_b, o_d, o_v
   );

endinterface

// File: rtl/zle_obuf.sv
// One-entry valid/backpressure register slice; may refill in the cycle it drains.
module zle_obuf
   import zle_pkg::*;
#(
   parameter int DW = ZLE_W + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [DW-1:0] in_d,
   input  logic          load,
   output logic [DW-1:0] o_d,
   output logic          o_v,
   input  logic          o_b,
   output logic          full,
   output logic          can_load
);

   logic          full_q;
   logic [DW-1:0] data_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         full_q <= 1'b0;
         // NOTE: the data register is reset too, since o_d is visible and defined as zero after reset.
         data_q <= '0;
      end else begin
         if (load) begin
            full_q <= 1'b1;
            data_q <= in_d;
         end else if (full_q && !o_b) begin
            full_q <= 1'b0;
         end
      end
   end

   assign full     = full_q;
   assign o_v      = full_q;
   assign o_d      = data_q;
   assign can_load = !full_q || !o_b;

endmodule

// File: rtl/zle_merge2.sv
// Round-robin burst merger of two ZLE token streams onto one tagged output channel.
module zle_merge2
   import zle_pkg::*;
#(
   parameter int W         = ZLE_W,
   parameter int MAX_BURST = 8,
   parameter int CW        = 4
) (
   input  logic        clock,
   input  logic        reset,
   zle_merge2_if.slave bus
);

   zle_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_q, last_d;
   logic          load;
   logic          can_load;
   logic          full_unused;
   logic [W:0]    in_d;
   logic [W:0]    o_d;
   logic          o_v;
   logic          a_b, b_b;
   logic          burst_end;

   assign burst_end = (cnt_q == CW'(MAX_BURST - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= TAG_B;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      load    = 1'b0;
      in_d    = {TAG_A, bus.a_d};
      a_b     = 1'b1;
      b_b     = 1'b1;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus.a_v && bus.b_v) begin
               state_d = (last_q == TAG_A) ? ST_GNT_B : ST_GNT_A;
            end else if (bus.a_v) begin
               state_d = ST_GNT_A;
            end else if (bus.b_v) begin
               state_d = ST_GNT_B;
            end
         end

         ST_GNT_A: begin
            a_b = !can_load;
            if (bus.a_v && can_load) begin
               load = 1'b1;
               if (burst_end) begin
                  state_d = ST_IDLE;
                  last_d  = TAG_A;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else if (!bus.a_v && bus.b_v) begin
               // Idle grant yields to a waiting peer without taking a token.
               state_d = ST_IDLE;
               last_d  = TAG_A;
            end
         end

         ST_GNT_B: begin
            b_b  = !can_load;
            in_d = {TAG_B, bus.b_d};
            if (bus.b_v && can_load) begin
               load = 1'b1;
               if (burst_end) begin
                  state_d = ST_IDLE;
                  last_d  = TAG_B;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else if (!bus.b_v && bus.a_v) begin
               state_d = ST_IDLE;
               last_d  = TAG_B;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // full mirrors o_v here; the slice exposes it for other stream blocks.
   zle_obuf #(
      .DW(W + 1)
   ) u_obuf (
      .clock    (clock),
      .reset    (reset),
      .in_d     (in_d),
      .load     (load),
      .o_d      (o_d),
      .o_v      (o_v),
      .o_b      (bus.o_b),
      .full     (full_unused),
      .can_load (can_load)
   );

   assign bus.a_b = a_b;
   assign bus.b_b = b_b;
   assign bus.o_d = o_d;
   assign bus.o_v = o_v;

endmodule
